// File: rtl/jala_pkg.sv
// Shared definitions for the program loader and the instruction-fetch path:
// loader FSM states, the program base address the control unit subtracts
// from PC, and the frame field widths.
package jala_pkg;

  localparam int BYTE_W            = 8;
  localparam int WORD_W            = 16;
  localparam int CNT_W             = 16;
  localparam int MAX_WORDS_DEFAULT = 1024;

  localparam logic [WORD_W-1:0] PROG_BASE_DEFAULT = 16'd10240;

  typedef enum logic [2:0] {
    S_CNT_HI,
    S_CNT_LO,
    S_DAT_HI,
    S_DAT_LO,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_e;

  // Instruction words travel high byte first.
  function automatic logic [WORD_W-1:0] pack_word(input logic [BYTE_W-1:0] hi,
                                                  input logic [BYTE_W-1:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Host byte stream (valid/ready) plus the instruction-memory write port.
// master = host side driving bytes, slave = loader accepting bytes and
// driving the memory write port.
interface program_loader_if;
  import jala_pkg::*;

  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_write;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_addr, mem_wdata, mem_write
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_addr, mem_wdata, mem_write
  );

endinterface

// File: rtl/loader_word_assembler.sv
// Pairs payload bytes into 16-bit words, keeps the running XOR checksum and
// registers the memory write (one-cycle strobe the cycle after the low byte).
// No backpressure of its own: the enables are already qualified transfers.
module loader_word_assembler
  import jala_pkg::*;
#(
  parameter logic [WORD_W-1:0] PROG_BASE = PROG_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic              hi_en_i,
  input  logic              lo_en_i,
  input  logic              acc_clr_i,
  input  logic [CNT_W-1:0]  word_idx_i,
  output logic [WORD_W-1:0] mem_addr_o,
  output logic [WORD_W-1:0] mem_wdata_o,
  output logic              mem_write_o,
  output logic [BYTE_W-1:0] acc_o
);

  logic [BYTE_W-1:0] hi_q,    hi_d;
  logic [BYTE_W-1:0] acc_q,   acc_d;
  logic [WORD_W-1:0] addr_q,  addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;

  // Next-state: latch the high byte, fold every payload byte into the XOR,
  // and on the low byte stage address/data with a single-cycle strobe.
  always_comb begin
    hi_d    = hi_q;
    acc_d   = acc_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = 1'b0;
    if (hi_en_i) begin
      hi_d = byte_i;
    end
    if (acc_clr_i) begin
      acc_d = '0;
    end else if (hi_en_i || lo_en_i) begin
      acc_d = acc_q ^ byte_i;
    end
    if (lo_en_i) begin
      write_d = 1'b1;
      wdata_d = pack_word(hi_q, byte_i);
      addr_d  = PROG_BASE + word_idx_i;
    end
  end

  // Assembler registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q    <= '0;
      acc_q   <= '0;
      addr_q  <= PROG_BASE;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      hi_q    <= hi_d;
      acc_q   <= acc_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_write_o = write_q;
  assign acc_o       = acc_q;

endmodule

// File: rtl/program_loader.sv
// Loads a framed program image into instruction memory at PROG_BASE, checks
// its XOR checksum, then releases the control unit from reset.
// Latency: word write strobe one cycle after its low byte; 1 byte/cycle.
// Backpressure: in_ready depends on state only, low in S_RUN and S_ERR.
module program_loader
  import jala_pkg::*;
#(
  parameter logic [WORD_W-1:0] PROG_BASE = PROG_BASE_DEFAULT,
  parameter int                MAX_WORDS = MAX_WORDS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reload,
  program_loader_if.slave   bus,
  output logic              cpu_rst,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  word_count
);

  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_WORDS);

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] cnt_hi_q, cnt_hi_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  word_count_q, word_count_d;
  logic              cpu_rst_q, done_q, error_q;
  logic              in_ready_w;
  logic              xfer;
  logic              hi_en, lo_en, acc_clr;
  logic [BYTE_W-1:0] acc;
  logic [CNT_W-1:0]  n_frame;
  logic [WORD_W-1:0] mem_addr_w, mem_wdata_w;
  logic              mem_write_w;

  // Byte acceptance is a pure function of state.
  always_comb begin
    in_ready_w = 1'b0;
    case (state_q)
      S_CNT_HI, S_CNT_LO, S_DAT_HI, S_DAT_LO, S_CSUM: in_ready_w = 1'b1;
      default:                                        in_ready_w = 1'b0;
    endcase
  end

  assign xfer    = bus.in_valid && in_ready_w;
  assign n_frame = {cnt_hi_q, bus.in_data};

  // Frame sequencing; reload overrides everything and discards any byte
  // transferred in the same cycle.
  always_comb begin
    state_d      = state_q;
    cnt_hi_d     = cnt_hi_q;
    n_d          = n_q;
    word_count_d = word_count_q;
    hi_en        = 1'b0;
    lo_en        = 1'b0;
    acc_clr      = 1'b0;
    if (reload) begin
      state_d      = S_CNT_HI;
      word_count_d = '0;
    end else begin
      case (state_q)
        S_CNT_HI: begin
          if (xfer) begin
            cnt_hi_d = bus.in_data;
            state_d  = S_CNT_LO;
          end
        end
        S_CNT_LO: begin
          if (xfer) begin
            n_d          = n_frame;
            acc_clr      = 1'b1;
            word_count_d = '0;
            if (n_frame > MAX_N) begin
              state_d = S_ERR;
            end else if (n_frame == '0) begin
              state_d = S_CSUM;
            end else begin
              state_d = S_DAT_HI;
            end
          end
        end
        S_DAT_HI: begin
          if (xfer) begin
            hi_en   = 1'b1;
            state_d = S_DAT_LO;
          end
        end
        S_DAT_LO: begin
          // word_count advances with the write strobe, so here it still
          // equals the index of the word being completed.
          if (xfer) begin
            lo_en        = 1'b1;
            word_count_d = word_count_q + 1'b1;
            state_d      = (word_count_q == n_q - 1'b1) ? S_CSUM : S_DAT_HI;
          end
        end
        S_CSUM: begin
          if (xfer) begin
            state_d = (bus.in_data == acc) ? S_RUN : S_ERR;
          end
        end
        S_RUN, S_ERR: state_d = state_q;
        default:      state_d = S_CNT_HI;
      endcase
    end
  end

  // State and status registers; status follows the state being entered so
  // cpu_rst/done/error switch on the same edge as the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_CNT_HI;
      cnt_hi_q     <= '0;
      n_q          <= '0;
      word_count_q <= '0;
      cpu_rst_q    <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_hi_q     <= cnt_hi_d;
      n_q          <= n_d;
      word_count_q <= word_count_d;
      cpu_rst_q    <= (state_d != S_RUN);
      done_q       <= (state_d == S_RUN);
      error_q      <= (state_d == S_ERR);
    end
  end

  loader_word_assembler #(
    .PROG_BASE (PROG_BASE)
  ) u_asm (
    .clk         (clk),
    .rst         (rst),
    .byte_i      (bus.in_data),
    .hi_en_i     (hi_en),
    .lo_en_i     (lo_en),
    .acc_clr_i   (acc_clr),
    .word_idx_i  (word_count_q),
    .mem_addr_o  (mem_addr_w),
    .mem_wdata_o (mem_wdata_w),
    .mem_write_o (mem_write_w),
    .acc_o       (acc)
  );

  assign bus.in_ready  = in_ready_w;
  assign bus.mem_addr  = mem_addr_w;
  assign bus.mem_wdata = mem_wdata_w;
  assign bus.mem_write = mem_write_w;
  assign cpu_rst       = cpu_rst_q;
  assign done          = done_q;
  assign error         = error_q;
  assign word_count    = word_count_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed frames plus random frames; expected
// memory writes and final status come from a frame-level model and are
// popped by a monitor whenever the loader writes or raises done/error.
module tb_program_loader;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct packed {
    logic        done;
    logic        error;
    logic        cpu_rst;
    logic [15:0] wc;
  } out_t;

  localparam int PB   = 10240;
  localparam int MAXW = 1024;

  logic        clk;
  logic        rst;
  logic        reload;
  logic        cpu_rst;
  logic        done;
  logic        error;
  logic [15:0] word_count;

  program_loader_if bus ();

  program_loader dut (
    .clk        (clk),
    .rst        (rst),
    .reload     (reload),
    .bus        (bus),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  wr_t        exp_wr[$];
  out_t       exp_out[$];
  logic [7:0] frm[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: a length above MAXW stops after the count bytes;
  // otherwise word i lands at PB+i and the status depends on the XOR.
  task automatic model_frame(output int n_send);
    int         n;
    logic [7:0] x;
    wr_t        w;
    out_t       o;
    n = {frm[0], frm[1]};
    if (n > MAXW) begin
      o      = '{done: 1'b0, error: 1'b1, cpu_rst: 1'b1, wc: 16'd0};
      n_send = 2;
    end else begin
      x = 8'h00;
      for (int i = 0; i < n; i++) begin
        w.addr = 16'(PB + i);
        w.data = {frm[2 + 2 * i], frm[3 + 2 * i]};
        x      = x ^ frm[2 + 2 * i] ^ frm[3 + 2 * i];
        exp_wr.push_back(w);
      end
      if (frm[2 + 2 * n] == x) o = '{done: 1'b1, error: 1'b0, cpu_rst: 1'b0, wc: 16'(n)};
      else                     o = '{done: 1'b0, error: 1'b1, cpu_rst: 1'b1, wc: 16'(n)};
      n_send = 3 + 2 * n;
    end
    exp_out.push_back(o);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int tries = 0;
    bit ok    = 1'b0;
    while (!ok && tries < 50) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        ok           = bus.in_ready;
      end
      tries++;
    end
    check("send_accept", 32'(ok), 32'd1);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic run_frame(input bit gaps);
    int n_send;
    model_frame(n_send);
    for (int i = 0; i < n_send; i++) send_byte(frm[i], gaps);
    idle(4);
  endtask

  // Reload with a junk byte presented alongside; that byte must be ignored.
  task automatic reload_pulse();
    @(negedge clk);
    reload       = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'($urandom);
    @(negedge clk);
    reload       = 1'b0;
    bus.in_valid = 1'b0;
    check("reload_done",  32'(done),         32'd0);
    check("reload_error", 32'(error),        32'd0);
    check("reload_cpurst", 32'(cpu_rst),     32'd1);
    check("reload_wc",    32'(word_count),   32'd0);
    check("reload_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic set_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                           input logic [7:0] b6, input int len);
    logic [7:0] t [7];
    t = '{b0, b1, b2, b3, b4, b5, b6};
    frm.delete();
    for (int i = 0; i < len; i++) frm.push_back(t[i]);
  endtask

  // Monitor: every write strobe and every rise of done/error consumes one
  // expectation.
  initial begin
    wr_t  e;
    out_t o;
    logic prev_st;
    logic st;
    prev_st = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.mem_write === 1'b1) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_write", 32'(bus.mem_addr), 32'hFFFF_FFFF);
        end else begin
          e = exp_wr.pop_front();
          check("wr_addr", 32'(bus.mem_addr),  32'(e.addr));
          check("wr_data", 32'(bus.mem_wdata), 32'(e.data));
        end
      end
      st = done | error;
      if (st && !prev_st) begin
        if (exp_out.size() == 0) begin
          check("unexpected_status", {30'd0, done, error}, 32'd0);
        end else begin
          o = exp_out.pop_front();
          check("st_done",   32'(done),       32'(o.done));
          check("st_error",  32'(error),      32'(o.error));
          check("st_cpurst", 32'(cpu_rst),    32'(o.cpu_rst));
          check("st_wc",     32'(word_count), 32'(o.wc));
        end
      end
      prev_st = st;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wr_t w;
    int  n;
    rst          = 1'b0;
    reload       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_addr",   32'(bus.mem_addr),  32'(PB));
    check("rst_wdata",  32'(bus.mem_wdata), 32'd0);
    check("rst_write",  32'(bus.mem_write), 32'd0);
    check("rst_cpurst", 32'(cpu_rst),       32'd1);
    check("rst_done",   32'(done),          32'd0);
    check("rst_error",  32'(error),         32'd0);
    check("rst_wc",     32'(word_count),    32'd0);
    check("rst_ready",  32'(bus.in_ready),  32'd1);
    rst = 1'b1;

    // Two-word frame, correct checksum, back to back.
    set_frame(8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40, 7);
    run_frame(1'b0);

    // Same frame, bad checksum.
    reload_pulse();
    set_frame(8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41, 7);
    run_frame(1'b0);
    check("ready_in_err", 32'(bus.in_ready), 32'd0);

    // Empty program.
    reload_pulse();
    set_frame(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3);
    run_frame(1'b0);

    // Length overflow: payload must not be accepted.
    reload_pulse();
    set_frame(8'h04, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2);
    run_frame(1'b0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    repeat (3) @(negedge clk);
    check("ready_overflow", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;

    // Two-word frame with random in_valid gaps.
    reload_pulse();
    set_frame(8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40, 7);
    run_frame(1'b1);

    // Reload after the first payload word, then a fresh one-word frame.
    reload_pulse();
    w = '{addr: 16'(PB), data: 16'h1234};
    exp_wr.push_back(w);
    set_frame(8'h00, 8'h02, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 4);
    for (int i = 0; i < 4; i++) send_byte(frm[i], 1'b0);
    idle(2);
    reload_pulse();
    set_frame(8'h00, 8'h01, 8'hBE, 8'hEF, 8'h51, 8'h00, 8'h00, 5);
    run_frame(1'b0);

    // Asynchronous reset in the middle of a frame.
    reload_pulse();
    w = '{addr: 16'(PB), data: 16'h1122};
    exp_wr.push_back(w);
    w = '{addr: 16'(PB + 1), data: 16'h3344};
    exp_wr.push_back(w);
    set_frame(8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 6);
    for (int i = 0; i < 6; i++) send_byte(frm[i], 1'b0);
    idle(3);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_addr",   32'(bus.mem_addr),  32'(PB));
    check("arst_wdata",  32'(bus.mem_wdata), 32'd0);
    check("arst_write",  32'(bus.mem_write), 32'd0);
    check("arst_cpurst", 32'(cpu_rst),       32'd1);
    check("arst_done",   32'(done),          32'd0);
    check("arst_error",  32'(error),         32'd0);
    check("arst_wc",     32'(word_count),    32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Random frames: short lengths, occasional bad checksum or overflow.
    for (int f = 0; f < 10; f++) begin
      logic [7:0] x;
      reload_pulse();
      frm.delete();
      n = (f == 4) ? int'($urandom_range(MAXW + 1, 3000)) : int'($urandom_range(0, 6));
      frm.push_back(8'(n >> 8));
      frm.push_back(8'(n));
      x = 8'h00;
      if (n <= MAXW) begin
        for (int i = 0; i < 2 * n; i++) begin
          frm.push_back(8'($urandom));
          x = x ^ frm[frm.size() - 1];
        end
        if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
        frm.push_back(x);
      end
      run_frame(1'($urandom_range(0, 1)));
    end

    idle(5);
    check("wr_queue_empty",  32'(exp_wr.size()),  32'd0);
    check("out_queue_empty", 32'(exp_out.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the instruction-fetch path. Receives a framed byte stream of a program image and writes 16-bit instruction words into the CPU's instruction memory, starting at PROG_BASE (10240).
- Holds the multicycle control unit in reset until the whole image has been written and its checksum verified, then releases it to run.
- Sits between the host byte link and the memory write port / CPU reset.

Parameters:
- PROG_BASE, 16'd10240, word address of the first instruction written.
- MAX_WORDS, 1024, largest accepted program length in words.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts the byte this cycle (transfer when in_valid && in_ready).
- reload  in  1  one-cycle pulse; abort or finish, then restart loading.
- mem_addr  out  16  instruction memory word address.
- mem_wdata  out  16  instruction word.
- mem_write  out  1  single-cycle write strobe.
- cpu_rst  out  1  active-high reset to the control unit; 1 while loading.
- done  out  1  image loaded and verified.
- error  out  1  checksum mismatch or length overflow.
- word_count  out  16  number of words written so far.

Behaviour:
- Frame format, in order:
  - CNT_HI, CNT_LO: big-endian word count N.
  - 2N payload bytes, high byte of each word first.
  - One checksum byte: XOR of all 2N payload bytes (0x00 when N=0).
- States: S_CNT_HI, S_CNT_LO, S_DAT_HI, S_DAT_LO, S_CSUM, S_RUN, S_ERR.
- Reset values (rst low, asynchronous):
  - state=S_CNT_HI.
  - mem_addr=PROG_BASE, mem_wdata=0, mem_write=0.
  - cpu_rst=1, done=0, error=0, word_count=0.
  - Internal count=0, checksum accumulator=0.
- in_ready is 1 in S_CNT_HI, S_CNT_LO, S_DAT_HI, S_DAT_LO and S_CSUM; 0 in S_RUN and S_ERR. It is combinational from state only. No state advances without a transfer.
- S_CNT_HI: on transfer, latch the high byte; go to S_CNT_LO.
- S_CNT_LO: on transfer, form N.
  - N > MAX_WORDS: go to S_ERR.
  - N == 0: go to S_CSUM.
  - Otherwise: go to S_DAT_HI.
  - Clear the accumulator and word_count.
- S_DAT_HI: on transfer, latch the high byte, XOR it into the accumulator; go to S_DAT_LO.
- S_DAT_LO: on transfer, XOR the byte into the accumulator.
  - On the next cycle, mem_write=1 for exactly one cycle, with mem_wdata={hi,lo} and mem_addr=PROG_BASE+word_count. word_count increments in that same cycle.
  - If this was word N, go to S_CSUM; otherwise go to S_DAT_HI.
  - Back-to-back bytes are legal. A write from the previous word can overlap acceptance of the next high byte. Sustained throughput is 1 byte/cycle.
- S_CSUM: on transfer, compare the byte with the accumulator.
  - Equal: go to S_RUN.
  - Not equal: go to S_ERR.
- S_RUN: cpu_rst=0, done=1. Both are registered and change on the clock edge that enters S_RUN.
- S_ERR: error=1, cpu_rst stays 1. The block remains here until reload or reset.
- reload in any state:
  - Next cycle: state=S_CNT_HI, cpu_rst=1, done=0, error=0, word_count=0.
  - Any in-flight write strobe still completes. A byte presented in the same cycle as reload is accepted but discarded.
- Arithmetic:
  - mem_addr is 16-bit and wraps modulo 2^16. With PROG_BASE=10240 and MAX_WORDS≤55296 it never wraps.
  - The accumulator is 8-bit XOR.
- Memory contents above PROG_BASE+N-1 are never touched.

Decomposition:
- Shared package jala_pkg holds:
  - The state enum.
  - PROG_BASE_DEFAULT=16'd10240, the same base the control unit subtracts from PC.
  - Frame field widths.
- One natural sub-module: loader_word_assembler. It holds the hi/lo byte pairing, the XOR accumulator and the write-strobe register. The top holds the FSM and the length/overflow check.

Test Plan:
- Frame 00 02 | 12 34 | AB CD | (12^34^AB^CD=0x40) 40 → writes 0x1234@10240 and 0xABCD@10241 as two single-cycle strobes. done=1, cpu_rst=0, word_count=2.
- Same frame with checksum byte 41 → both writes occur; error=1, cpu_rst=1, done=0, in_ready=0.
- Frame 00 00 | 00 → no mem_write; done=1 one cycle after the checksum transfer.
- Frame 04 01 (N=1025 > MAX_WORDS) → S_ERR immediately, no writes, payload bytes not accepted.
- in_valid toggled randomly during the 2-word frame → identical writes, addresses and checksum result to the back-to-back case.
- reload pulse after the first payload word, then a fresh 1-word frame 00 01 | BE EF | 51 → write 0xBEEF@10240, word_count=1, done=1. Asserting rst low mid-frame returns all outputs to reset values asynchronously.
